i2c_ram_ctrl: RTL and testbench

Byte-level sequencer between the I2C target PHY and the 8-bit RAM array in the TinyTapeout RAM design. It turns PHY byte events into RAM accesses: in a write transaction, the first data byte loads an address pointer and later bytes are written with auto-increment. In a read transaction, bytes are prefetched from the pointer location and handed to the PHY one at a time. The pointer persists across transactions, so a write of the pointer byte alone followed by a read gives random-access reads.

---
 rtl/ram_ctrl_pkg.sv | 16 +
 rtl/i2c_ram_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_i2c_ram_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_ctrl_pkg.sv
// Shared types and constants for the I2C-to-RAM byte sequencer.
package ram_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PTR,
    WRITE,
    RD_FETCH,
    RD_WAIT,
    RD_HOLD
  } ram_ctrl_state_e;

  localparam int         RAM_CTRL_AW_DEFAULT = 3;
  localparam logic [7:0] RAM_CTRL_FILL       = 8'hFF;

endpackage

// File: rtl/i2c_ram_ctrl.sv
// Byte sequencer between the I2C target PHY and the RAM array; the pointer persists across transactions.
// RAM_CTRL_WRAP_EN: pointer wraps at the top of RAM; undefined, it saturates and reads return RAM_CTRL_FILL.
module i2c_ram_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int AW = RAM_CTRL_AW_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ev_start,
  input  logic            ev_stop,
  input  logic            ev_addr,
  input  logic            ev_rw,
  input  logic            rx_valid,
  input  logic [7:0]      rx_data,
  output logic            rx_ack,
  // tx_valid stays high until the PHY pulses tx_take (byte consumed) or tx_nack
  // (master ends the read); tx_data is stable whenever tx_valid is high.
  output logic [7:0]      tx_data,
  output logic            tx_valid,
  input  logic            tx_take,
  input  logic            tx_nack,
  output logic            ram_en,
  output logic            ram_we,
  output logic [AW-1:0]   ram_addr,
  output logic [7:0]      ram_wdata,
  input  logic [7:0]      ram_rdata,
  output logic            busy,
  output ram_ctrl_state_e state_dbg
);

  localparam int            DEPTH   = 2 ** AW;
  localparam logic [AW-1:0] PTR_MAX = AW'(DEPTH - 1);

  ram_ctrl_state_e state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic            sat_q, sat_d;
  logic            rx_ack_q, rx_ack_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_valid_q, tx_valid_d;
  logic            ram_en_q, ram_en_d;
  logic            ram_we_q, ram_we_d;
  logic [AW-1:0]   ram_addr_q, ram_addr_d;
  logic [7:0]      ram_wdata_q, ram_wdata_d;
  logic [AW:0]     adv;
  logic [7:0]      rd_byte;

  // Returns {saturated, next pointer}.
  function automatic logic [AW:0] ptr_advance(input logic [AW-1:0] p);
`ifdef RAM_CTRL_WRAP_EN
    return {1'b0, p + AW'(1)};
`else
    if (p == PTR_MAX) return {1'b1, p};
    else              return {1'b0, p + AW'(1)};
`endif
  endfunction

  assign adv     = ptr_advance(ptr_q);
  assign rd_byte = sat_q ? RAM_CTRL_FILL : ram_rdata;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    sat_d       = sat_q;
    rx_ack_d    = rx_ack_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;

    // The write pointer moves as the write strobe completes, even if the bus ends meanwhile.
    if (ram_en_q && ram_we_q) begin
      ptr_d = adv[AW-1:0];
      sat_d = adv[AW];
    end

    if (ev_start || ev_stop) begin
      state_d    = IDLE;
      tx_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ev_addr) begin
            if (ev_rw) begin
              state_d    = RD_FETCH;
              ram_en_d   = !sat_d;
              ram_addr_d = ptr_d;
            end else begin
              state_d = PTR;
            end
          end
        end
        PTR: begin
          if (rx_valid) begin
            if (int'(rx_data) < DEPTH) begin
              ptr_d    = rx_data[AW-1:0];
              sat_d    = 1'b0;
              rx_ack_d = 1'b1;
              state_d  = WRITE;
            end else begin
              rx_ack_d = 1'b0;
            end
          end
        end
        WRITE: begin
          if (rx_valid) begin
            if (!sat_q) begin
              ram_en_d    = 1'b1;
              ram_we_d    = 1'b1;
              ram_addr_d  = ptr_q;
              ram_wdata_d = rx_data;
              rx_ack_d    = 1'b1;
            end else begin
              rx_ack_d = 1'b0;
            end
          end
        end
        RD_FETCH: state_d = RD_WAIT;
        RD_WAIT: begin
          tx_data_d  = rd_byte;
          tx_valid_d = 1'b1;
          if (!sat_q) begin
            ptr_d = adv[AW-1:0];
            sat_d = adv[AW];
          end
          state_d = RD_HOLD;
        end
        RD_HOLD: begin
          if (tx_nack) begin
            tx_valid_d = 1'b0;
            state_d    = IDLE;
          end else if (tx_take) begin
            tx_valid_d = 1'b0;
            state_d    = RD_FETCH;
            ram_en_d   = !sat_q;
            ram_addr_d = ptr_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      sat_q       <= 1'b0;
      rx_ack_q    <= 1'b0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      sat_q       <= sat_d;
      rx_ack_q    <= rx_ack_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  // The fetched byte is presented in the RAM's data cycle so a read completes one cycle after the strobe.
  assign tx_valid  = tx_valid_q | (state_q == RD_WAIT);
  assign tx_data   = (state_q == RD_WAIT) ? rd_byte : tx_data_q;
  assign rx_ack    = rx_ack_q;
  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_i2c_ram_ctrl.sv
// Bench for i2c_ram_ctrl: transaction-level pointer/memory model, RAM behavioural model, write scoreboard.
module tb_i2c_ram_ctrl;
  import ram_ctrl_pkg::*;

  logic            clk;
  logic            rst_n;
  logic            ev_start, ev_stop, ev_addr, ev_rw;
  logic            rx_valid;
  logic [7:0]      rx_data;
  logic            rx_ack;
  logic [7:0]      tx_data;
  logic            tx_valid, tx_take, tx_nack;
  logic            ram_en, ram_we;
  logic [2:0]      ram_addr;
  logic [7:0]      ram_wdata, ram_rdata;
  logic            busy;
  ram_ctrl_state_e state_dbg;

  int checks = 0;
  int errors = 0;
  int rd_strobes = 0;

  logic [7:0]  ram [8];
  logic [7:0]  m_mem [8];
  int          m_ptr;
  bit          m_sat;
  bit          m_ptr_phase;
  logic [10:0] exp_q[$];

  i2c_ram_ctrl #(.AW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .ev_start(ev_start), .ev_stop(ev_stop), .ev_addr(ev_addr), .ev_rw(ev_rw),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ack(rx_ack),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_take(tx_take), .tx_nack(tx_nack),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .busy(busy), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "bench timeout");
  end

  // RAM: synchronous read, data valid the cycle after the strobe
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram[ram_addr] = ram_wdata;
      else        ram_rdata <= ram[ram_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard on RAM writes
  always @(negedge clk) begin
    if (ram_en && ram_we) begin
      if (exp_q.size() == 0) check("wr_unexpected", {ram_addr, ram_wdata}, 11'h7FF);
      else check("wr", {ram_addr, ram_wdata}, exp_q.pop_front());
    end
    if (ram_en && !ram_we) rd_strobes++;
  end

  // reference model: pointer step after an access
  function automatic void m_advance();
`ifdef RAM_CTRL_WRAP_EN
    m_ptr = (m_ptr + 1) % 8;
`else
    if (m_ptr == 7) m_sat = 1'b1;
    else            m_ptr = m_ptr + 1;
`endif
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    ev_start = 1'b1; tick(); ev_start = 1'b0;
  endtask

  task automatic begin_write();
    pulse_start();
    ev_addr = 1'b1; ev_rw = 1'b0; tick(); ev_addr = 1'b0;
    m_ptr_phase = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ack, strobe;
    strobe = 1'b0;
    if (m_ptr_phase) begin
      if (b < 8) begin
        m_ptr = b; m_sat = 1'b0; m_ptr_phase = 1'b0; ack = 1'b1;
      end else ack = 1'b0;
    end else if (m_sat) begin
      ack = 1'b0;
    end else begin
      exp_q.push_back({3'(m_ptr), b});
      m_mem[m_ptr] = b;
      m_advance();
      ack = 1'b1; strobe = 1'b1;
    end
    rx_valid = 1'b1; rx_data = b; tick(); rx_valid = 1'b0;
    check("rx_ack", rx_ack, ack);
    check("wr_en", ram_en, strobe);
    tick();
  endtask

  task automatic end_txn();
    ev_stop = 1'b1; tick(); ev_stop = 1'b0;
    check("stop_busy", busy, 0);
  endtask

  task automatic read_txn(input int n_take, input bit use_nack);
    logic [7:0] exp_b;
    pulse_start();
    ev_addr = 1'b1; ev_rw = 1'b1; tick(); ev_addr = 1'b0; ev_rw = 1'b0;
    for (int i = 0; i <= n_take; i++) begin
      check("rd_en", ram_en, !m_sat);
      if (!m_sat) begin
        check("rd_addr", ram_addr, m_ptr);
        check("rd_we", ram_we, 0);
      end
      tick();
      if (m_sat) exp_b = 8'hFF;
      else begin
        exp_b = m_mem[m_ptr];
        m_advance();
      end
      check("tx_valid", tx_valid, 1);
      check("tx_data", tx_data, exp_b);
      tick();
      check("tx_hold", tx_valid, 1);
      if (i < n_take) begin
        tx_take = 1'b1; tick(); tx_take = 1'b0;
        check("take_drop", tx_valid, 0);
      end
    end
    if (use_nack) begin
      tx_nack = 1'b1; tick(); tx_nack = 1'b0;
      check("nack_valid", tx_valid, 0);
      check("nack_state", 32'(state_dbg), 32'(IDLE));
    end else begin
      ev_stop = 1'b1; tick(); ev_stop = 1'b0;
      check("stop_valid", tx_valid, 0);
    end
    check("rd_busy", busy, 0);
  endtask

  initial begin
    int rd0;
    ev_start = 0; ev_stop = 0; ev_addr = 0; ev_rw = 0;
    rx_valid = 0; rx_data = 0; tx_take = 0; tx_nack = 0;
    ram_rdata = 8'h00;
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      m_mem[i] = 8'($urandom);
      ram[i]   = m_mem[i];
    end
    m_ptr = 0; m_sat = 1'b0; m_ptr_phase = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;

    check("rst_rx_ack", rx_ack, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_ram_en", ram_en, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_wdata", ram_wdata, 0);
    check("rst_busy", busy, 0);
    tick();
    read_txn(0, 1'b1);

    // auto-increment write, then re-point and read back
    begin_write(); send_byte(8'h02); send_byte(8'hA5); send_byte(8'h5A); end_txn();
    begin_write(); send_byte(8'h02); end_txn();
    read_txn(1, 1'b0);

    // out-of-range pointer byte
    begin_write(); send_byte(8'h08); end_txn();
    read_txn(0, 1'b1);

    // end-of-range behaviour
    begin_write(); send_byte(8'h07); send_byte(8'h11); send_byte(8'h22); end_txn();
    begin_write(); send_byte(8'h07); end_txn();
    read_txn(1, 1'b1);

    // two takes then nack: three fetches
    begin_write(); send_byte(8'h00); end_txn();
    rd0 = rd_strobes;
    read_txn(2, 1'b1);
    check("rd_strobes", rd_strobes - rd0, 3);

    // STOP colliding with a data byte drops it
    begin_write(); send_byte(8'h01); send_byte(8'h44);
    rx_valid = 1'b1; rx_data = 8'h33; ev_stop = 1'b1; tick();
    rx_valid = 1'b0; ev_stop = 1'b0;
    check("collide_busy", busy, 0);
    tick();
    read_txn(0, 1'b1);

    // asynchronous reset cuts an in-flight fetch
    begin_write(); send_byte(8'h03); end_txn();
    pulse_start();
    ev_addr = 1'b1; ev_rw = 1'b1; tick(); ev_addr = 1'b0; ev_rw = 1'b0;
    check("pre_rst_en", ram_en, 1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_en", ram_en, 0);
    check("async_rst_busy", busy, 0);
    m_ptr = 0; m_sat = 1'b0; m_ptr_phase = 1'b0;
    tick(); rst_n = 1'b1; tick();
    read_txn(0, 1'b1);

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        int n;
        begin_write();
        send_byte(8'($urandom_range(0, 9)));
        n = $urandom_range(0, 4);
        for (int k = 0; k < n; k++) send_byte(8'($urandom));
        end_txn();
      end else begin
        read_txn($urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end
      repeat ($urandom_range(0, 2)) tick();
    end

    tick();
    check("wr_pending", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
